regs: RTL and testbench
=======================

REGS -- requirements
Module: regs

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter DATA_W, default 32, SHALL set the register data width.
REQ-003 Parameter REG_NUM, default 32, SHALL set the register count; the address width is 5 bits.
REQ-004 Port clk, input, 1: the rising-edge clock.
REQ-005 Port rst, input, 1: the asynchronous active-high reset.
REQ-006 Port id2regs_rs1_addr_i, input, 5: the source-1 read address from the decoder.
REQ-007 Port id2regs_rs2_addr_i, input, 5: the source-2 read address from the decoder.
REQ-008 Port regs2id_rs1_data_o, output, 32: source-1 read data (combinational).
REQ-009 Port regs2id_rs2_data_o, output, 32: source-2 read data (combinational).
REQ-010 Port id2regs_issue_en_i, input, 1: the decoder issues an instruction whose write-back enable is set.
REQ-011 Port id2regs_issue_rd_i, input, 5: the destination register of the issued instruction.
REQ-012 Port wb2regs_we_i, input, 1: write-back strobe.
REQ-013 Port wb2regs_rd_addr_i, input, 5: write-back destination.
REQ-014 Port wb2regs_rd_data_i, input, 32: write-back data.
REQ-015 Port regs2cu_stall_o, output, 1: hazard stall request to the control unit (combinational).
REQ-016 Port regs2cu_pending_o, output, 32: scoreboard bitmap, where bit n is set while xn has a write-back outstanding.

Function
REQ-017 Storage: a 32x32 register array; x0 SHALL always read 0 and SHALL ignore writes.
REQ-018 Write: at a rising clk edge with wb2regs_we_i=1 and rd_addr!=0, the array SHALL store wb2regs_rd_data_i; there is one write per cycle.
REQ-019 Read: each read port SHALL return 0 for address 0, otherwise the array content, with zero-cycle latency.
REQ-020 Scoreboard set: at a rising edge, if issue_en=1, stall_o=0 and issue_rd!=0, pending[issue_rd] SHALL become 1.
REQ-021 Scoreboard clear: at a rising edge, if we=1 and rd_addr!=0, pending[rd_addr] SHALL become 0.
REQ-022 Same-edge set and clear of the same register: set SHALL win, so the bit ends at 1.
REQ-023 Stall: stall_o=1 if any of the following holds (address 0 is never hazardous): rs1 is pending, rs2 is pending, or issue_en=1 with issue_rd pending (WAW).
REQ-024 While stall_o=1, issue_en SHALL be ignored and the scoreboard SHALL NOT set any bit.
REQ-025 Write-back to a register that is not pending SHALL still update the array and SHALL leave pending unchanged.
REQ-026 With pending bit n set, exactly one outstanding producer of xn exists; WAW stalling guarantees this.

Reset
REQ-027 Asserting rst SHALL immediately clear all 32 registers and all pending bits; regs2id_*_data_o SHALL then read 0 and stall_o SHALL be 0.
REQ-028 A write-back or issue coincident with, or in flight at, reset SHALL be discarded.
REQ-029 After rst deasserts, the first rising edge SHALL operate normally.

Configuration
REQ-030 Macro REGS_BYPASS_EN, when defined: a read address equal to a nonzero wb2regs_rd_addr_i with we=1 SHALL return wb2regs_rd_data_i in the same cycle.
REQ-031 Under REGS_BYPASS_EN, the stall logic SHALL treat that register as not pending in that cycle.
REQ-032 Without REGS_BYPASS_EN, reads SHALL return array contents only; the stall SHALL persist until the edge after write-back, so a dependent instruction issues one cycle later.

Verification
REQ-033 Reset, read x5 and x0 -> both read 0x00000000, stall_o=0, pending_o=0.
REQ-034 WB x3=0xDEADBEEF, next cycle read rs1=3 -> 0xDEADBEEF; WB x0=0x1234 -> x0 still reads 0.
REQ-035 Issue rd=7; next cycle rs2=7 -> stall_o=1; WB x7=0x55 -> with bypass: same cycle rs2 data=0x55 and stall_o=0; without bypass: stall_o=0 one cycle later and data=0x55.
REQ-036 Issue rd=4 while pending[4]=1 -> stall_o=1 and pending_o unchanged; same edge issue rd=9 plus WB rd=9 -> pending[9]=1.
REQ-037 Issue rd=2, assert rst mid-cycle before WB -> pending_o=0 and x2 reads 0 immediately; post-reset WB x2=0xA -> x2 reads 0xA.

Source files
------------

// File: rtl/regs.sv
// -----------------------------------------------------------------------------
// regs -- integer register file with issue scoreboard and hazard stall
//
// Purpose:
//   Holds the architectural registers x0..x(REG_NUM-1). It provides two
//   combinational read ports for the decoder and one write-back port. A
//   pending bitmap tracks registers with an outstanding write-back. The
//   block raises a stall request on RAW hazards (rs1/rs2 pending) and on
//   WAW hazards (issue to a pending rd). x0 reads zero and is never
//   written or marked pending.
//
// Optional feature (macro REGS_BYPASS_EN):
//   When the macro is defined, a read that matches the current write-back
//   destination returns the write-back data in the same cycle. The stall
//   logic then treats that register as already resolved. When the macro
//   is undefined, reads return array contents only. A dependent
//   instruction then issues on the cycle after the write-back edge.
//
// Ports:
//   clk                 in   rising-edge clock
//   rst                 in   asynchronous active-high reset
//   id2regs_rs1_addr_i  in   source-1 read address
//   id2regs_rs2_addr_i  in   source-2 read address
//   regs2id_rs1_data_o  out  source-1 read data (combinational)
//   regs2id_rs2_data_o  out  source-2 read data (combinational)
//   id2regs_issue_en_i  in   issue of an instruction that writes back
//   id2regs_issue_rd_i  in   destination of the issued instruction
//   wb2regs_we_i        in   write-back strobe
//   wb2regs_rd_addr_i   in   write-back destination
//   wb2regs_rd_data_i   in   write-back data
//   regs2cu_stall_o     out  hazard stall request (combinational)
//   regs2cu_pending_o   out  scoreboard bitmap, bit n = xn outstanding
// -----------------------------------------------------------------------------
module regs #(
  parameter int DATA_W  = 32,
  parameter int REG_NUM = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          id2regs_rs1_addr_i,
  input  logic [4:0]          id2regs_rs2_addr_i,
  output logic [DATA_W-1:0]   regs2id_rs1_data_o,
  output logic [DATA_W-1:0]   regs2id_rs2_data_o,
  input  logic                id2regs_issue_en_i,
  input  logic [4:0]          id2regs_issue_rd_i,
  input  logic                wb2regs_we_i,
  input  logic [4:0]          wb2regs_rd_addr_i,
  input  logic [DATA_W-1:0]   wb2regs_rd_data_i,
  output logic                regs2cu_stall_o,
  output logic [REG_NUM-1:0]  regs2cu_pending_o
);

  logic [DATA_W-1:0]  r_regs [REG_NUM];
  logic [REG_NUM-1:0] r_pending;

  logic               w_wb_hit;
  logic               w_rs1_pend;
  logic               w_rs2_pend;
  logic               w_waw_pend;
  logic               w_stall;
  logic [REG_NUM-1:0] w_set;
  logic [REG_NUM-1:0] w_clr;
  logic [DATA_W-1:0]  w_rs1_data;
  logic [DATA_W-1:0]  w_rs2_data;

  // Array read with x0 hard-wired to zero
  function automatic logic [DATA_W-1:0] arr_read(input logic [4:0] addr);
    logic [DATA_W-1:0] v;
    if (addr == 5'd0) begin
      v = {DATA_W{1'b0}};
    end else begin
      v = r_regs[addr];
    end
    return v;
  endfunction

  // Scoreboard lookup; x0 is never hazardous
  function automatic logic is_pend(input logic [4:0] addr);
    logic p;
    if (addr == 5'd0) begin
      p = 1'b0;
    end else begin
      p = r_pending[addr];
    end
    return p;
  endfunction

  // One-hot decode of a register address
  function automatic logic [REG_NUM-1:0] onehot(input logic [4:0] addr);
    logic [REG_NUM-1:0] v;
    v = {{(REG_NUM-1){1'b0}}, 1'b1} << addr;
    return v;
  endfunction

  // Read data, hazard detection and scoreboard update vectors
  always_comb begin
    w_wb_hit   = wb2regs_we_i && (wb2regs_rd_addr_i != 5'd0);
`ifdef REGS_BYPASS_EN
    // A register being written back this cycle is forwarded and not a hazard
    if (w_wb_hit && (wb2regs_rd_addr_i == id2regs_rs1_addr_i)) begin
      w_rs1_data = wb2regs_rd_data_i;
      w_rs1_pend = 1'b0;
    end else begin
      w_rs1_data = arr_read(id2regs_rs1_addr_i);
      w_rs1_pend = is_pend(id2regs_rs1_addr_i);
    end
    if (w_wb_hit && (wb2regs_rd_addr_i == id2regs_rs2_addr_i)) begin
      w_rs2_data = wb2regs_rd_data_i;
      w_rs2_pend = 1'b0;
    end else begin
      w_rs2_data = arr_read(id2regs_rs2_addr_i);
      w_rs2_pend = is_pend(id2regs_rs2_addr_i);
    end
    if (w_wb_hit && (wb2regs_rd_addr_i == id2regs_issue_rd_i)) begin
      w_waw_pend = 1'b0;
    end else begin
      w_waw_pend = is_pend(id2regs_issue_rd_i);
    end
`else
    w_rs1_data = arr_read(id2regs_rs1_addr_i);
    w_rs2_data = arr_read(id2regs_rs2_addr_i);
    w_rs1_pend = is_pend(id2regs_rs1_addr_i);
    w_rs2_pend = is_pend(id2regs_rs2_addr_i);
    w_waw_pend = is_pend(id2regs_issue_rd_i);
`endif
    w_stall = w_rs1_pend || w_rs2_pend || (id2regs_issue_en_i && w_waw_pend);

    if (id2regs_issue_en_i && !w_stall && (id2regs_issue_rd_i != 5'd0)) begin
      w_set = onehot(id2regs_issue_rd_i);
    end else begin
      w_set = {REG_NUM{1'b0}};
    end
    if (w_wb_hit) begin
      w_clr = onehot(wb2regs_rd_addr_i);
    end else begin
      w_clr = {REG_NUM{1'b0}};
    end
  end

  // Register array: async clear, one write-back per cycle, x0 never written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < REG_NUM; i++) begin
        r_regs[i] <= {DATA_W{1'b0}};
      end
    end else if (w_wb_hit) begin
      r_regs[wb2regs_rd_addr_i] <= wb2regs_rd_data_i;
    end
  end

  // Scoreboard: clear on write-back, set on issue; set wins on collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= {REG_NUM{1'b0}};
    end else begin
      r_pending <= (r_pending & ~w_clr) | w_set;
    end
  end

  assign regs2id_rs1_data_o = w_rs1_data;
  assign regs2id_rs2_data_o = w_rs2_data;
  assign regs2cu_stall_o    = w_stall;
  assign regs2cu_pending_o  = r_pending;

endmodule

// File: tb/tb_regs.sv
module tb_regs;

  logic        clk;
  logic        rst;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        issue_en;
  logic [4:0]  issue_rd;
  logic        we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        stall;
  logic [31:0] pending;

  int total;
  int bad;

  regs #(.DATA_W(32), .REG_NUM(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .id2regs_rs1_addr_i (rs1_addr),
    .id2regs_rs2_addr_i (rs2_addr),
    .regs2id_rs1_data_o (rs1_data),
    .regs2id_rs2_data_o (rs2_data),
    .id2regs_issue_en_i (issue_en),
    .id2regs_issue_rd_i (issue_rd),
    .wb2regs_we_i       (we),
    .wb2regs_rd_addr_i  (wb_addr),
    .wb2regs_rd_data_i  (wb_data),
    .regs2cu_stall_o    (stall),
    .regs2cu_pending_o  (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // advance past the next rising edge; inputs then change 1 ns after it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_en = 1'b0; issue_rd = 5'd0;
    we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    // write-back and issue while reset is held must be discarded
    we = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_00FF;
    issue_en = 1'b1; issue_rd = 5'd6;
    step();
    step();
    idle();
    rs1_addr = 5'd5; rs2_addr = 5'd0;
    #2;
    total++; if (rs1_data !== 32'h0) begin $display("FAIL reset_rs1 got=%h exp=%h", rs1_data, 32'h0); bad++; end
    total++; if (rs2_data !== 32'h0) begin $display("FAIL reset_rs2 got=%h exp=%h", rs2_data, 32'h0); bad++; end
    total++; if (stall !== 1'b0) begin $display("FAIL reset_stall got=%b exp=0", stall); bad++; end
    total++; if (pending !== 32'h0) begin $display("FAIL reset_pending got=%h exp=%h", pending, 32'h0); bad++; end
    rst = 1'b0;
    step();
    total++; if (rs1_data !== 32'h0) begin $display("FAIL reset_wb_discard got=%h exp=%h", rs1_data, 32'h0); bad++; end
  endtask

  task automatic test_write();
    idle();
    we = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD_BEEF;
    rs1_addr = 5'd3;
    #2;
`ifdef REGS_BYPASS_EN
    total++; if (rs1_data !== 32'hDEAD_BEEF) begin $display("FAIL wr_same_cycle got=%h exp=%h", rs1_data, 32'hDEAD_BEEF); bad++; end
`else
    total++; if (rs1_data !== 32'h0) begin $display("FAIL wr_same_cycle got=%h exp=%h", rs1_data, 32'h0); bad++; end
`endif
    step();
    idle();
    rs1_addr = 5'd3;
    #2;
    total++; if (rs1_data !== 32'hDEAD_BEEF) begin $display("FAIL wr_x3 got=%h exp=%h", rs1_data, 32'hDEAD_BEEF); bad++; end
    total++; if (pending !== 32'h0) begin $display("FAIL wr_nopend got=%h exp=%h", pending, 32'h0); bad++; end
    we = 1'b1; wb_addr = 5'd0; wb_data = 32'h0000_1234;
    rs1_addr = 5'd0; rs2_addr = 5'd0;
    step();
    idle();
    #2;
    total++; if (rs1_data !== 32'h0) begin $display("FAIL wr_x0_rs1 got=%h exp=%h", rs1_data, 32'h0); bad++; end
    total++; if (rs2_data !== 32'h0) begin $display("FAIL wr_x0_rs2 got=%h exp=%h", rs2_data, 32'h0); bad++; end
  endtask

  task automatic test_raw();
    idle();
    issue_en = 1'b1; issue_rd = 5'd7;
    #2;
    total++; if (stall !== 1'b0) begin $display("FAIL raw_issue_stall got=%b exp=0", stall); bad++; end
    step();
    idle();
    rs2_addr = 5'd7;
    #2;
    total++; if (pending !== 32'h0000_0080) begin $display("FAIL raw_pending got=%h exp=%h", pending, 32'h0000_0080); bad++; end
    total++; if (stall !== 1'b1) begin $display("FAIL raw_stall got=%b exp=1", stall); bad++; end
    we = 1'b1; wb_addr = 5'd7; wb_data = 32'h0000_0055;
    #2;
`ifdef REGS_BYPASS_EN
    total++; if (stall !== 1'b0) begin $display("FAIL raw_wb_stall got=%b exp=0", stall); bad++; end
    total++; if (rs2_data !== 32'h0000_0055) begin $display("FAIL raw_wb_data got=%h exp=%h", rs2_data, 32'h0000_0055); bad++; end
`else
    total++; if (stall !== 1'b1) begin $display("FAIL raw_wb_stall got=%b exp=1", stall); bad++; end
    total++; if (rs2_data !== 32'h0) begin $display("FAIL raw_wb_data got=%h exp=%h", rs2_data, 32'h0); bad++; end
`endif
    step();
    idle();
    rs2_addr = 5'd7;
    #2;
    total++; if (stall !== 1'b0) begin $display("FAIL raw_after_stall got=%b exp=0", stall); bad++; end
    total++; if (rs2_data !== 32'h0000_0055) begin $display("FAIL raw_after_data got=%h exp=%h", rs2_data, 32'h0000_0055); bad++; end
    total++; if (pending !== 32'h0) begin $display("FAIL raw_after_pending got=%h exp=%h", pending, 32'h0); bad++; end
  endtask

  task automatic test_waw();
    idle();
    issue_en = 1'b1; issue_rd = 5'd4;
    step();
    #2;
    total++; if (pending !== 32'h0000_0010) begin $display("FAIL waw_set got=%h exp=%h", pending, 32'h0000_0010); bad++; end
    total++; if (stall !== 1'b1) begin $display("FAIL waw_stall got=%b exp=1", stall); bad++; end
    step();
    total++; if (pending !== 32'h0000_0010) begin $display("FAIL waw_hold got=%h exp=%h", pending, 32'h0000_0010); bad++; end
    // RAW stall on rs1 must block an unrelated issue
    issue_rd = 5'd12; rs1_addr = 5'd4;
    #2;
    total++; if (stall !== 1'b1) begin $display("FAIL waw_rs1_stall got=%b exp=1", stall); bad++; end
    step();
    total++; if (pending !== 32'h0000_0010) begin $display("FAIL waw_blocked got=%h exp=%h", pending, 32'h0000_0010); bad++; end
    // set and clear of x9 on one edge: set wins
    idle();
    issue_en = 1'b1; issue_rd = 5'd9;
    we = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_0099;
    #2;
    total++; if (stall !== 1'b0) begin $display("FAIL waw_x9_stall got=%b exp=0", stall); bad++; end
    step();
    idle();
    rs1_addr = 5'd9;
    #2;
    total++; if (pending !== 32'h0000_0210) begin $display("FAIL waw_setwins got=%h exp=%h", pending, 32'h0000_0210); bad++; end
    // drain x4 and x9
    we = 1'b1; wb_addr = 5'd4; wb_data = 32'h0000_0044;
    step();
    we = 1'b1; wb_addr = 5'd9; wb_data = 32'h0000_0999;
    step();
    idle();
    rs1_addr = 5'd9; rs2_addr = 5'd4;
    #2;
    total++; if (pending !== 32'h0) begin $display("FAIL waw_drain got=%h exp=%h", pending, 32'h0); bad++; end
    total++; if (rs1_data !== 32'h0000_0999) begin $display("FAIL waw_x9 got=%h exp=%h", rs1_data, 32'h0000_0999); bad++; end
    total++; if (rs2_data !== 32'h0000_0044) begin $display("FAIL waw_x4 got=%h exp=%h", rs2_data, 32'h0000_0044); bad++; end
  endtask

  task automatic test_reset_mid();
    idle();
    we = 1'b1; wb_addr = 5'd2; wb_data = 32'h0000_0077;
    step();
    idle();
    issue_en = 1'b1; issue_rd = 5'd2;
    step();
    idle();
    rs1_addr = 5'd2; rs2_addr = 5'd3;
    #1;
    total++; if (pending !== 32'h0000_0004) begin $display("FAIL mid_pre_pending got=%h exp=%h", pending, 32'h0000_0004); bad++; end
    total++; if (rs1_data !== 32'h0000_0077) begin $display("FAIL mid_pre_x2 got=%h exp=%h", rs1_data, 32'h0000_0077); bad++; end
    rst = 1'b1;
    #1;
    total++; if (pending !== 32'h0) begin $display("FAIL mid_pending got=%h exp=%h", pending, 32'h0); bad++; end
    total++; if (rs1_data !== 32'h0) begin $display("FAIL mid_x2 got=%h exp=%h", rs1_data, 32'h0); bad++; end
    total++; if (rs2_data !== 32'h0) begin $display("FAIL mid_x3 got=%h exp=%h", rs2_data, 32'h0); bad++; end
    total++; if (stall !== 1'b0) begin $display("FAIL mid_stall got=%b exp=0", stall); bad++; end
    step();
    rst = 1'b0;
    we = 1'b1; wb_addr = 5'd2; wb_data = 32'h0000_000A;
    step();
    idle();
    rs1_addr = 5'd2;
    #2;
    total++; if (rs1_data !== 32'h0000_000A) begin $display("FAIL post_x2 got=%h exp=%h", rs1_data, 32'h0000_000A); bad++; end
    total++; if (pending !== 32'h0) begin $display("FAIL post_pending got=%h exp=%h", pending, 32'h0); bad++; end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    idle();
    test_reset();
    test_write();
    test_raw();
    test_waw();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
